// File: rtl/ub_nbank_pkg.sv
// Shared types and helpers for the N-bank unified buffer.
// Imported by the buffer top and its stages.
package ub_nbank_pkg;

  typedef enum logic {
    W_IDLE,
    W_BURST
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_ISSUE
  } rd_state_t;

  localparam int unsigned UB_MAX_AW = 16;

  // In-bank offset increment; wraps inside a power-of-two bank
  function automatic logic [UB_MAX_AW-1:0] ub_addr_next(
    input logic [UB_MAX_AW-1:0] addr,
    input int unsigned          depth
  );
    return (addr + 1'b1) & UB_MAX_AW'(depth - 1);
  endfunction

endpackage

// File: rtl/ub_sdp_ram.sv
// Simple dual-port block RAM, one write and one registered read port.
// Address is {bank, offset}; contents are never reset.
module ub_sdp_ram #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = "block" *)
  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/unified_buffer_nbank.sv
// N-bank ring-ordered unified buffer between loader and array feeder.
// Producer fills and commits banks; consumer reads and releases them.
module unified_buffer_nbank #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 128,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BANK_W     = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_cmd_valid,
  output logic                  wr_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [ADDR_WIDTH:0]   wr_cmd_count,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_commit_valid,
  output logic                  wr_commit_ready,
  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
  input  logic [ADDR_WIDTH:0]   rd_cmd_count,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  input  logic                  rd_release_valid,
  output logic                  rd_release_ready,
  output logic [BANK_W-1:0]     wr_bank,
  output logic [BANK_W-1:0]     rd_bank,
  output logic [BANK_W:0]       full_count,
  output logic                  busy,
  output logic                  cmd_err
);

  import ub_nbank_pkg::*;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  wr_state_t             w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH:0]   w_cnt;

  rd_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_cnt;

  logic                  infl;
  logic                  infl_last;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] s0_data;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s0_last;
  logic                  s1_last;
  logic [DATA_WIDTH-1:0] ram_q;

  logic not_full;
  logic not_empty;
  logic wr_cmd_hs;
  logic wr_data_hs;
  logic commit_hs;
  logic rd_cmd_hs;
  logic rel_hs;
  logic pop;
  logic issue;
  logic [2:0] credit;

  assign not_full  = full_count < (BANK_W+1)'(NUM_BANKS);
  assign not_empty = full_count != '0;

  assign wr_cmd_ready     = (w_state == W_IDLE) && not_full;
  assign wr_commit_ready  = (w_state == W_IDLE) && not_full;
  assign wr_data_ready    = (w_state == W_BURST);
  assign rd_cmd_ready     = (r_state == R_IDLE) && not_empty;
  assign rd_release_ready = (r_state == R_IDLE) && (occ == 2'd0)
                          && !infl && not_empty;

  assign wr_cmd_hs  = wr_cmd_valid && wr_cmd_ready;
  assign wr_data_hs = wr_data_valid && wr_data_ready;
  assign commit_hs  = wr_commit_valid && wr_commit_ready;
  assign rd_cmd_hs  = rd_cmd_valid && rd_cmd_ready;
  assign rel_hs     = rd_release_valid && rd_release_ready;

  assign rd_data_valid = (occ != 2'd0);
  assign rd_data       = s0_data;
  assign rd_last       = s0_last && rd_data_valid;
  assign pop           = rd_data_valid && rd_data_ready;

  // Credit counts the slot freed by this cycle's pop so a steady
  // consumer sees one beat per cycle without overrunning the buffer.
  assign credit = 3'(occ) + 3'(infl) - 3'(pop);
  assign issue  = (r_state == R_ISSUE) && (credit < 3'd2);

  assign busy = (w_state != W_IDLE) || (r_state != R_IDLE)
              || (occ != 2'd0) || infl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= '0;
      rd_bank    <= '0;
      full_count <= '0;
      cmd_err    <= 1'b0;
    end else begin
      if (commit_hs) wr_bank <= wr_bank + 1'b1;
      if (rel_hs)    rd_bank <= rd_bank + 1'b1;
      unique case ({commit_hs, rel_hs})
        2'b10:   full_count <= full_count + 1'b1;
        2'b01:   full_count <= full_count - 1'b1;
        default: ;
      endcase
      cmd_err <= (wr_cmd_hs && wr_cmd_count == '0)
              || (rd_cmd_hs && rd_cmd_count == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_cnt   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: if (wr_cmd_hs && wr_cmd_count != '0) begin
          w_state <= W_BURST;
          w_addr  <= wr_cmd_addr;
          w_cnt   <= wr_cmd_count;
        end
        W_BURST: if (wr_data_hs) begin
          w_addr <= ADDR_WIDTH'(ub_addr_next(UB_MAX_AW'(w_addr), DEPTH));
          w_cnt  <= w_cnt - 1'b1;
          if (w_cnt == CNT_ONE) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      infl      <= issue;
      infl_last <= issue && (r_cnt == CNT_ONE);
      unique case (r_state)
        R_IDLE: if (rd_cmd_hs && rd_cmd_count != '0) begin
          r_state <= R_ISSUE;
          r_addr  <= rd_cmd_addr;
          r_cnt   <= rd_cmd_count;
        end
        R_ISSUE: if (issue) begin
          r_addr <= ADDR_WIDTH'(ub_addr_next(UB_MAX_AW'(r_addr), DEPTH));
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CNT_ONE) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Two-entry output buffer; slot 0 is the head seen on rd_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ     <= 2'd0;
      s0_data <= '0;
      s1_data <= '0;
      s0_last <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      unique case ({infl, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            s0_data <= ram_q;
            s0_last <= infl_last;
          end else begin
            s1_data <= ram_q;
            s1_last <= infl_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          s0_data <= s1_data;
          s0_last <= s1_last;
          occ     <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            s0_data <= ram_q;
            s0_last <= infl_last;
          end else begin
            s0_data <= s1_data;
            s0_last <= s1_last;
            s1_data <= ram_q;
            s1_last <= infl_last;
          end
        end
        default: ;
      endcase
    end
  end

  ub_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (BANK_W + ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_data_hs),
    .waddr ({wr_bank, w_addr}),
    .wdata (wr_data),
    .re    (issue),
    .raddr ({rd_bank, r_addr}),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_unified_buffer_nbank.sv
// Directed plus randomized bench for unified_buffer_nbank.
// Reference: per-bank array model, bank FIFO counters, expected-beat lists.
module tb_unified_buffer_nbank;

  localparam int DW = 256;
  localparam int D  = 128;
  localparam int NB = 2;
  localparam int AW = 7;
  localparam int BW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_cmd_valid = 1'b0;
  logic          wr_cmd_ready;
  logic [AW-1:0] wr_cmd_addr = '0;
  logic [AW:0]   wr_cmd_count = '0;
  logic          wr_data_valid = 1'b0;
  logic          wr_data_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_commit_valid = 1'b0;
  logic          wr_commit_ready;
  logic          rd_cmd_valid = 1'b0;
  logic          rd_cmd_ready;
  logic [AW-1:0] rd_cmd_addr = '0;
  logic [AW:0]   rd_cmd_count = '0;
  logic          rd_data_valid;
  logic          rd_data_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_release_valid = 1'b0;
  logic          rd_release_ready;
  logic [BW-1:0] wr_bank;
  logic [BW-1:0] rd_bank;
  logic [BW:0]   full_count;
  logic          busy;
  logic          cmd_err;

  unified_buffer_nbank #(
    .DATA_WIDTH (DW),
    .DEPTH      (D),
    .NUM_BANKS  (NB)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_cmd_valid     (wr_cmd_valid),
    .wr_cmd_ready     (wr_cmd_ready),
    .wr_cmd_addr      (wr_cmd_addr),
    .wr_cmd_count     (wr_cmd_count),
    .wr_data_valid    (wr_data_valid),
    .wr_data_ready    (wr_data_ready),
    .wr_data          (wr_data),
    .wr_commit_valid  (wr_commit_valid),
    .wr_commit_ready  (wr_commit_ready),
    .rd_cmd_valid     (rd_cmd_valid),
    .rd_cmd_ready     (rd_cmd_ready),
    .rd_cmd_addr      (rd_cmd_addr),
    .rd_cmd_count     (rd_cmd_count),
    .rd_data_valid    (rd_data_valid),
    .rd_data_ready    (rd_data_ready),
    .rd_data          (rd_data),
    .rd_last          (rd_last),
    .rd_release_valid (rd_release_valid),
    .rd_release_ready (rd_release_ready),
    .wr_bank          (wr_bank),
    .rd_bank          (rd_bank),
    .full_count       (full_count),
    .busy             (busy),
    .cmd_err          (cmd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mm [NB][D];
  int m_fc = 0;
  int m_wb = 0;
  int m_rb = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    total++;
    bad++;
    $display("FAIL %s timeout", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_wr_cmd_ready", wr_cmd_ready, 1);
    chk("rst_commit_ready", wr_commit_ready, 1);
    chk("rst_rd_cmd_ready", rd_cmd_ready, 0);
    chk("rst_release_ready", rd_release_ready, 0);
    chk("rst_wr_data_ready", wr_data_ready, 0);
    chk("rst_rd_valid", rd_data_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_full_count", full_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_err", cmd_err, 0);
  endtask

  task automatic do_commit();
    int n = 0;
    wr_commit_valid = 1'b1;
    while (!wr_commit_ready && n < 100) begin tick(); n++; end
    if (!wr_commit_ready) begin
      wr_commit_valid = 1'b0;
      tmo("commit");
      return;
    end
    tick();
    wr_commit_valid = 1'b0;
    m_fc++;
    m_wb = (m_wb + 1) % NB;
    chk("commit_fc", full_count, m_fc);
    chk("commit_wb", wr_bank, m_wb);
  endtask

  task automatic do_release();
    int n = 0;
    rd_release_valid = 1'b1;
    while (!rd_release_ready && n < 100) begin tick(); n++; end
    if (!rd_release_ready) begin
      rd_release_valid = 1'b0;
      tmo("release");
      return;
    end
    tick();
    rd_release_valid = 1'b0;
    m_fc--;
    m_rb = (m_rb + 1) % NB;
    chk("release_fc", full_count, m_fc);
    chk("release_rb", rd_bank, m_rb);
  endtask

  task automatic do_write(input int addr, input int cnt, input bit fixed);
    int n = 0;
    logic [DW-1:0] d;
    wr_cmd_valid = 1'b1;
    wr_cmd_addr  = AW'(addr);
    wr_cmd_count = (AW+1)'(cnt);
    while (!wr_cmd_ready && n < 100) begin tick(); n++; end
    if (!wr_cmd_ready) begin
      wr_cmd_valid = 1'b0;
      tmo("wr_cmd");
      return;
    end
    tick();
    wr_cmd_valid = 1'b0;
    if (cnt == 0) begin
      chk("wzero_err", cmd_err, 1);
      chk("wzero_data_ready", wr_data_ready, 0);
      chk("wzero_cmd_ready", wr_cmd_ready, 1);
      tick();
      chk("wzero_err_clear", cmd_err, 0);
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      d = fixed ? DW'(8'hA0 + i) : rnd();
      wr_data_valid = 1'b1;
      wr_data = d;
      n = 0;
      while (!wr_data_ready && n < 100) begin tick(); n++; end
      if (!wr_data_ready) begin
        wr_data_valid = 1'b0;
        tmo("wr_data");
        return;
      end
      tick();
      mm[m_wb][(addr + i) % D] = d;
    end
    wr_data_valid = 1'b0;
    chk("wr_end_data_ready", wr_data_ready, 0);
  endtask

  // mode 0: ready held high, 1: fixed stall pattern, 2: random ready
  task automatic do_read(input int addr, input int cnt, input int mode);
    int n = 0;
    int got = 0;
    int cyc = 0;
    int first = -1;
    bit stalled = 0;
    logic [DW-1:0] sd;
    logic sl;
    logic [7:0] pat = 8'b0110_1001;
    logic [DW-1:0] exp_q [$];
    for (int i = 0; i < cnt; i++) exp_q.push_back(mm[m_rb][(addr + i) % D]);
    rd_cmd_valid = 1'b1;
    rd_cmd_addr  = AW'(addr);
    rd_cmd_count = (AW+1)'(cnt);
    while (!rd_cmd_ready && n < 100) begin tick(); n++; end
    if (!rd_cmd_ready) begin
      rd_cmd_valid = 1'b0;
      tmo("rd_cmd");
      return;
    end
    tick();
    rd_cmd_valid = 1'b0;
    if (cnt == 0) begin
      chk("rzero_err", cmd_err, 1);
      chk("rzero_valid", rd_data_valid, 0);
      chk("rzero_cmd_ready", rd_cmd_ready, 1);
      tick();
      chk("rzero_err_clear", cmd_err, 0);
      chk("rzero_valid2", rd_data_valid, 0);
      return;
    end
    while (got < cnt && cyc < 1000) begin
      unique case (mode)
        0:       rd_data_ready = 1'b1;
        1:       rd_data_ready = pat[cyc % 8];
        default: rd_data_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        chk("stall_valid", rd_data_valid, 1);
        chk("stall_data", rd_data, sd);
        chk("stall_last", rd_last, sl);
        stalled = 0;
      end
      if (rd_data_valid) begin
        if (first < 0) first = cyc;
        if (rd_data_ready) begin
          chk("rd_data", rd_data, exp_q[got]);
          chk("rd_last", rd_last, got == cnt - 1);
          got++;
        end else begin
          stalled = 1;
          sd = rd_data;
          sl = rd_last;
        end
      end
      tick();
      cyc++;
    end
    if (got < cnt) tmo("rd_beats");
    if (mode == 0) chk("rd_latency", first, 2);
    rd_data_ready = 1'b1;
    tick();
    chk("rd_no_extra", rd_data_valid, 0);
    rd_data_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ra [NB];
    int rc [NB];
    int off;
    int len;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk_reset_vals();

    do_write(0, 4, 1'b1);
    do_commit();
    do_read(0, 4, 0);
    do_release();

    do_write(126, 4, 1'b0);
    do_commit();
    do_read(126, 4, 0);
    do_read(0, 2, 0);
    do_release();

    do_write(10, 8, 1'b0);
    do_commit();
    do_read(10, 8, 1);
    do_release();

    do_commit();
    do_commit();
    chk("full_fc", full_count, 2);
    chk("full_wr_cmd_ready", wr_cmd_ready, 0);
    chk("full_commit_ready", wr_commit_ready, 0);
    do_release();
    chk("after_rel_wr_cmd_ready", wr_cmd_ready, 1);
    chk("after_rel_commit_ready", wr_commit_ready, 1);
    wr_commit_valid  = 1'b1;
    rd_release_valid = 1'b1;
    chk("both_commit_ready", wr_commit_ready, 1);
    chk("both_release_ready", rd_release_ready, 1);
    tick();
    wr_commit_valid  = 1'b0;
    rd_release_valid = 1'b0;
    m_wb = (m_wb + 1) % NB;
    m_rb = (m_rb + 1) % NB;
    chk("both_fc", full_count, m_fc);
    chk("both_wb", wr_bank, m_wb);
    chk("both_rb", rd_bank, m_rb);
    do_release();
    chk("empty_rd_cmd_ready", rd_cmd_ready, 0);
    chk("empty_release_ready", rd_release_ready, 0);

    do_write(5, 0, 1'b0);
    do_commit();
    do_read(5, 0, 0);
    do_release();

    for (int it = 0; it < 12; it++) begin
      for (int b = 0; b < NB; b++) begin
        ra[b] = $urandom_range(0, D - 1);
        rc[b] = $urandom_range(1, 20);
        do_write(ra[b], rc[b], 1'b0);
        do_commit();
      end
      for (int b = 0; b < NB; b++) begin
        off = $urandom_range(0, rc[b] - 1);
        len = $urandom_range(1, rc[b] - off);
        do_read((ra[b] + off) % D, len, 2);
        do_release();
      end
    end

    do_commit();
    rd_cmd_valid = 1'b1;
    rd_cmd_addr  = '0;
    rd_cmd_count = (AW+1)'(8);
    tick();
    rd_cmd_valid = 1'b0;
    wr_cmd_valid = 1'b1;
    wr_cmd_addr  = AW'(3);
    wr_cmd_count = (AW+1)'(10);
    tick();
    wr_cmd_valid  = 1'b0;
    wr_data_valid = 1'b1;
    wr_data       = rnd();
    repeat (3) tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_rd_valid", rd_data_valid, 1);
    #2 rst_n = 1'b0;
    wr_data_valid = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    m_fc = 0;
    m_wb = 0;
    m_rb = 0;
    tick();
    chk_reset_vals();

    do_write(40, 3, 1'b1);
    do_commit();
    do_read(40, 3, 0);
    do_release();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_buffer_nbank.md
# unified_buffer_nbank

Parametrised N-bank successor to the two-bank unified buffer, sitting between the host/DMA loader and the systolic-array feeder. The producer fills one bank at a time and commits it. The consumer reads committed banks in commit order and releases them. Banks therefore form a ring-ordered bank FIFO. All command, data and bank-transfer paths use valid/ready handshakes with full read back-pressure.

## Interface
- DATA_WIDTH, 256: bits per entry.
- DEPTH, 128: entries per bank, power of two, ≥4.
- NUM_BANKS, 2: bank count, power of two, ≥2.
- ADDR_WIDTH, $clog2(DEPTH): in-bank address width.
- BANK_W, $clog2(NUM_BANKS): bank index width.
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_cmd_valid / wr_cmd_ready  in / out  1  write-burst command handshake.
- wr_cmd_addr  in  ADDR_WIDTH  start offset in the current write bank.
- wr_cmd_count  in  ADDR_WIDTH+1  beats in the burst; legal range 1..DEPTH.
- wr_data_valid / wr_data_ready  in / out  1  write-beat handshake.
- wr_data  in  DATA_WIDTH  write beat.
- wr_commit_valid / wr_commit_ready  in / out  1  marks the write bank full and advances wr_bank.
- rd_cmd_valid / rd_cmd_ready  in / out  1  read-burst command handshake.
- rd_cmd_addr  in  ADDR_WIDTH  start offset in the current read bank.
- rd_cmd_count  in  ADDR_WIDTH+1  beats; legal range 1..DEPTH.
- rd_data_valid / rd_data_ready  out / in  1  read-beat handshake.
- rd_data  out  DATA_WIDTH  read beat.
- rd_last  out  1  high on the final beat of a burst.
- rd_release_valid / rd_release_ready  in / out  1  frees the read bank and advances rd_bank.
- wr_bank, rd_bank  out  BANK_W  current bank pointers.
- full_count  out  BANK_W+1  number of committed, unreleased banks.
- busy  out  1  either engine is not idle, or the output buffer is non-empty.
- cmd_err  out  1  one-cycle pulse when a command with count==0 is accepted.

## Operation
- **Bank state**
  - full_count increments on a commit handshake and decrements on a release handshake.
  - A commit and a release in the same cycle leave full_count unchanged and advance both pointers.
  - Pointers wrap modulo NUM_BANKS.
- **Write FSM, W_IDLE → W_BURST → W_IDLE**
  - wr_cmd_ready = W_IDLE && full_count<NUM_BANKS.
  - On command accept: latch addr and count, enter W_BURST.
  - wr_data_ready = W_BURST.
  - Each data handshake writes mem[wr_bank][addr] and does addr+1 mod DEPTH (wraps inside the bank). It also decrements the remaining count.
  - Return to W_IDLE on the handshake in which remaining count is 1.
- **Commit**
  - wr_commit_ready = W_IDLE && full_count<NUM_BANKS.
  - Committing a bank that was never written is legal.
- **Read FSM, R_IDLE → R_ISSUE → R_IDLE**
  - rd_cmd_ready = R_IDLE && full_count>0.
  - R_ISSUE issues one RAM read per cycle while output-buffer occupancy plus in-flight reads is less than 2.
  - Address increments mod DEPTH.
  - Leave R_ISSUE after the last issue.
  - Output buffer: 2-entry FIFO. rd_last travels with the final beat.
- **Release**
  - rd_release_ready = R_IDLE && output buffer empty && no reads in flight && full_count>0.
- **Zero count**
  - The command is accepted, cmd_err pulses, no beats are transferred, and the engine stays idle.
- **Same bank read and written**
  - Impossible by construction: the read bank is always full and the write bank is always non-full. No collision logic is needed.
- **Reset**
  - Aborts any burst and empties the output buffer.
  - Sets pointers and full_count to 0.
  - RAM contents are not cleared.

## Timing
- **Reset values**
  - wr_cmd_ready=1, wr_commit_ready=1.
  - rd_cmd_ready=0, rd_release_ready=0, wr_data_ready=0.
  - rd_data_valid=0, rd_data=0, rd_last=0.
  - wr_bank=0, rd_bank=0, full_count=0, busy=0, cmd_err=0.
- **Write timing**
  - A write beat is stored at its handshake edge.
  - It is readable by a read command issued in the following cycle.
- **Read latency**
  - Command accepted at edge T: first RAM read issued at T+1, rd_data_valid first high in the cycle after edge T+2.
  - With rd_data_ready held high, throughput is 1 beat/cycle.
- **Back-pressure**
  - rd_data and rd_last hold stable while valid && !ready.
  - No beat is lost or duplicated.
- **Ready updates**
  - Ready outputs are registered.
  - After a release or commit handshake at edge T, the dependent readies update at edge T.

## Structure
- Package ub_nbank_pkg holds:
  - wr_state_t {W_IDLE, W_BURST}
  - rd_state_t {R_IDLE, R_ISSUE}
  - a ub_addr_next() helper for the mod-DEPTH increment
- Sub-module ub_sdp_ram:
  - simple dual-port block RAM, NUM_BANKS*DEPTH × DATA_WIDTH
  - address {bank, offset}
  - registered read, 1-cycle latency
  - ram_style "block"

## Test plan
- **Reset:** assert rst_n low mid-burst → all outputs at their reset values, full_count=0, busy=0 on the first cycle after release.
- **Basic burst:** write addr 0, count 4, data 0xA0..0xA3; commit; read addr 0, count 4 → 0xA0..0xA3 in order, rd_last on beat 4 only, first valid 2 cycles after command accept.
- **Wrap-around:** DEPTH=128, write addr 126, count 4, then read addr 126, count 4 → data lands at offsets 126, 127, 0, 1 and reads back identically.
- **Back-pressure:** 8-beat read with rd_data_ready pattern 1,0,0,1,0,1,1,0… → exactly 8 beats delivered, correct order, data stable during stalls.
- **Full/empty with NUM_BANKS=2:**
  - Commit twice → full_count=2; wr_cmd_ready and wr_commit_ready low.
  - Release → both readies high next cycle.
  - Commit and release in the same cycle → full_count unchanged, both pointers advance.
- **Zero count:** write or read command with count=0 → cmd_err high for exactly 1 cycle, no data handshakes, engine ready again the next cycle.
